// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one floating-point multiplier among NUM_REQ lanes,
// with a level start/done handshake and a watchdog that aborts a stuck multiply.
module mult_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] w_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] x_in,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         result,
  output logic                          err,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          mul_start,
  output logic [DATA_WIDTH-1:0]         mul_w,
  output logic [DATA_WIDTH-1:0]         mul_x,
  input  logic                          mul_done,
  input  logic [DATA_WIDTH-1:0]         mul_result
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RELEASE, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    pick_id_c;
  logic               pick_vld_c;
  int unsigned        scan_c;
  logic [WD_W-1:0]    watchdog;
  logic [WD_W-1:0]    wd_inc_c;
  logic               timeout_c;
  logic [NUM_REQ-1:0] ack_sel_c;

  // First requesting lane searching upward from rr_ptr, with wrap-around.
  always_comb begin
    pick_vld_c = 1'b0;
    pick_id_c  = '0;
    scan_c     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_c = 32'(rr_ptr) + k;
      if (scan_c >= NUM_REQ) scan_c = scan_c - NUM_REQ;
      if (!pick_vld_c && req[ID_W'(scan_c)]) begin
        pick_vld_c = 1'b1;
        pick_id_c  = ID_W'(scan_c);
      end
    end
  end

  assign wd_inc_c  = watchdog + WD_W'(1);
  assign timeout_c = (wd_inc_c == WD_W'(TIMEOUT - 1));
  assign ack_sel_c = NUM_REQ'(1) << grant_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld_c && !mul_done) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mul_done || timeout_c) state_nxt = RELEASE;
      RELEASE: state_nxt = DRAIN;
      // The multiplier keeps done high briefly after start drops; never restart on it.
      DRAIN:   if (!mul_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs, operand latch, watchdog and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      ack       <= '0;
      err       <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
      mul_start <= 1'b0;
      mul_w     <= '0;
      mul_x     <= '0;
      watchdog  <= '0;
    end else begin
      ack       <= '0;
      err       <= 1'b0;
      busy      <= (state_nxt != IDLE);
      mul_start <= (state_nxt == ISSUE) || (state_nxt == WAIT);
      case (state)
        IDLE: begin
          if (state_nxt == ISSUE) begin
            grant_id <= pick_id_c;
            mul_w    <= w_in[pick_id_c*DATA_WIDTH +: DATA_WIDTH];
            mul_x    <= x_in[pick_id_c*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        ISSUE: watchdog <= '0;
        WAIT: begin
          watchdog <= wd_inc_c;
          if (mul_done) begin
            result <= mul_result;
            ack    <= ack_sel_c;
          end else if (timeout_c) begin
            result <= '0;
            err    <= 1'b1;
            ack    <= ack_sel_c;
          end
        end
        RELEASE: rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        default: ;
      endcase
    end
  end

endmodule
